inst_encoder: RTL and testbench

//  Packs decoded fields back into a 32-bit RV32E instruction word: the encoding counterpart of the decode-side immediate

---
 rtl/inst_encoder.sv | 198 +++++++++++++++++++
 tb/tb_inst_encoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32E instruction word encoder with legality checks and output FIFO

`ifndef TYPE_BUS
`define TYPE_BUS 2:0
`endif
`ifndef INST_R
`define INST_R 3'd0
`endif
`ifndef INST_I
`define INST_I 3'd1
`endif
`ifndef INST_S
`define INST_S 3'd2
`endif
`ifndef INST_B
`define INST_B 3'd3
`endif
`ifndef INST_U
`define INST_U 3'd4
`endif
`ifndef INST_J
`define INST_J 3'd5
`endif

module inst_encoder #(
  parameter int FIFO_DEPTH  = 2,
  parameter int CNT_W       = 16,
  parameter int CHECK_RV32E = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [`TYPE_BUS] in_type,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [2:0]       out_errcode,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_DW = $clog2(FIFO_DEPTH + 1);
  localparam logic REG_CHK = (CHECK_RV32E != 0);

  localparam logic [2:0] E_OK    = 3'd0;
  localparam logic [2:0] E_RANGE = 3'd1;
  localparam logic [2:0] E_ALIGN = 3'd2;
  localparam logic [2:0] E_REG   = 3'd3;
  localparam logic [2:0] E_TYPE  = 3'd4;

  typedef struct packed {
    logic [2:0]  code;
    logic [31:0] inst;
  } entry_t;

  // An immediate fits an N-bit signed field when all bits above N-1 equal bit N-1.
  logic fits12, fits13, fits21;
  assign fits12 = (&in_imm32[31:11]) | ~(|in_imm32[31:11]);
  assign fits13 = (&in_imm32[31:12]) | ~(|in_imm32[31:12]);
  assign fits21 = (&in_imm32[31:20]) | ~(|in_imm32[31:20]);

  logic [31:0] raw_word, enc_word;
  logic [2:0]  enc_code;
  logic        use_rd, use_rs1, use_rs2, type_bad, reg_bad, align_bad, range_bad;

  // Field packing per type, legality checks, and priority-resolved error code.
  always_comb begin
    raw_word  = '0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    type_bad  = 1'b0;
    align_bad = 1'b0;
    range_bad = 1'b0;
    case (in_type)
      `INST_R: begin
        raw_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      `INST_I: begin
        raw_word = {in_imm32[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        use_rd = 1'b1; use_rs1 = 1'b1;
        range_bad = !fits12;
      end
      `INST_S: begin
        raw_word = {in_imm32[11:5], in_rs2, in_rs1, in_funct3, in_imm32[4:0], in_opcode};
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        range_bad = !fits12;
      end
      `INST_B: begin
        raw_word = {in_imm32[12], in_imm32[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm32[4:1], in_imm32[11], in_opcode};
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        align_bad = in_imm32[0];
        range_bad = !fits13;
      end
      `INST_U: begin
        raw_word = {in_imm32[31:12], in_rd, in_opcode};
        use_rd = 1'b1;
        align_bad = |in_imm32[11:0];
      end
      `INST_J: begin
        raw_word = {in_imm32[20], in_imm32[10:1], in_imm32[11], in_imm32[19:12], in_rd, in_opcode};
        use_rd = 1'b1;
        align_bad = in_imm32[0];
        range_bad = !fits21;
      end
      default: type_bad = 1'b1;
    endcase
    reg_bad = REG_CHK && ((use_rd && in_rd[4]) || (use_rs1 && in_rs1[4]) || (use_rs2 && in_rs2[4]));
    if (type_bad)       enc_code = E_TYPE;
    else if (reg_bad)   enc_code = E_REG;
    else if (align_bad) enc_code = E_ALIGN;
    else if (range_bad) enc_code = E_RANGE;
    else                enc_code = E_OK;
    enc_word = (enc_code == E_OK) ? raw_word : 32'h0;
  end

  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_DW-1:0]  count_q, count_d;
  logic [CNT_W-1:0]   enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;
  logic               full, empty, push, pop;

  assign full      = (count_q == CNT_DW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign pop       = !empty && out_ready;
  assign out_valid = !empty;
  assign out_inst    = empty ? 32'h0 : mem_q[rd_ptr_q].inst;
  assign out_errcode = empty ? 3'd0  : mem_q[rd_ptr_q].code;
  assign out_err     = (out_errcode != E_OK);
  assign enc_cnt   = enc_cnt_q;
  assign err_cnt   = err_cnt_q;

  // FIFO next state: write at tail on accept, advance head on pop, pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {enc_code, enc_word};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop)      count_d = count_q + CNT_DW'(1);
    else if (!push && pop) count_d = count_q - CNT_DW'(1);
  end

  // Saturating statistics; a clear takes precedence over a same-cycle increment.
  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      enc_cnt_d = '0;
      err_cnt_d = '0;
    end else if (push) begin
      if (!(&enc_cnt_q)) enc_cnt_d = enc_cnt_q + CNT_W'(1);
      if ((enc_code != E_OK) && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any queued words.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - self-checking bench for inst_encoder

module tb_inst_encoder;

  localparam int DEPTH = 2;
  localparam int CW    = 4;
  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_type = '0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm32 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic          out_err;
  logic [2:0]    out_errcode;
  logic [CW-1:0] enc_cnt, err_cnt;
  logic          clr_cnt = 1'b0;

  int total = 0;
  int bad = 0;

  inst_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW), .CHECK_RV32E(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm32(in_imm32),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
    .out_errcode(out_errcode), .enc_cnt(enc_cnt), .err_cnt(err_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {code, word} from the encoding rules using plain arithmetic on integers.
  function automatic logic [34:0] ref_enc(input logic [2:0] t, input logic [6:0] op,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] imm);
    longint s = longint'($signed(imm));
    longint u = longint'(imm);
    longint w = 0;
    int code = 0;
    bit use_rd  = (t == T_R || t == T_I || t == T_U || t == T_J);
    bit use_rs1 = (t == T_R || t == T_I || t == T_S || t == T_B);
    bit use_rs2 = (t == T_R || t == T_S || t == T_B);
    bit reg_bad = (use_rd && rd >= 16) || (use_rs1 && rs1 >= 16) || (use_rs2 && rs2 >= 16);
    bit align_bad = ((t == T_B || t == T_J) && (u % 2 != 0)) || (t == T_U && (u % 4096 != 0));
    bit range_bad = ((t == T_I || t == T_S) && (s < -2048 || s > 2047)) ||
                    (t == T_B && (s < -4096 || s > 4095)) ||
                    (t == T_J && (s < -1048576 || s > 1048575));
    longint base = (longint'(rs1) << 15) | (longint'(f3) << 12) | longint'(op);
    if (t > T_J)        code = 4;
    else if (reg_bad)   code = 3;
    else if (align_bad) code = 2;
    else if (range_bad) code = 1;
    case (t)
      T_R: w = (longint'(f7) << 25) | (longint'(rs2) << 20) | base | (longint'(rd) << 7);
      T_I: w = ((u & 'hFFF) << 20) | base | (longint'(rd) << 7);
      T_S: w = (((u >> 5) & 'h7F) << 25) | (longint'(rs2) << 20) | base | ((u & 'h1F) << 7);
      T_B: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (longint'(rs2) << 20) | base |
               (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7);
      T_U: w = (u & 'hFFFFF000) | (longint'(rd) << 7) | longint'(op);
      T_J: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20) |
               (((u >> 12) & 'hFF) << 12) | (longint'(rd) << 7) | longint'(op);
      default: w = 0;
    endcase
    if (code != 0) w = 0;
    return {3'(code), w[31:0]};
  endfunction

  task automatic set_fields(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm32 = imm;
  endtask

  // Present one word (already on the field inputs) until accepted; starts and ends at a negedge.
  task automatic send_cur(input string tag);
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({tag, "_accept_timeout"}, 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] inst, input logic [2:0] code);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_inst"}, out_inst, inst);
    check({tag, "_err"}, 32'(out_err), (code != 0) ? 1 : 0);
    check({tag, "_code"}, 32'(out_errcode), 32'(code));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: v = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: v = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      3: v = $urandom;
      4: v = $urandom & 32'hFFFFF000;
      default: case ($urandom_range(0, 11))
        0: v = 32'h7FF;       1: v = 32'h800;       2: v = 32'hFFFFF800;  3: v = 32'hFFFFF7FF;
        4: v = 32'hFFE;       5: v = 32'h1000;      6: v = 32'hFFFFF000;  7: v = 32'hFFFFEFFE;
        8: v = 32'hFFFFE;     9: v = 32'h100000;    10: v = 32'hFFF00000; default: v = 32'hFFEFFFFE;
      endcase
    endcase
    if ($urandom_range(0, 1) == 1) v = v & 32'hFFFFFFFE;
    return v;
  endfunction

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
  endfunction

  logic [31:0] got [$];
  logic [34:0] q [$];

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_inst", out_inst, 0);
    check("rst_err", 32'(out_err), 0);
    check("rst_code", 32'(out_errcode), 0);
    check("rst_enc", 32'(enc_cnt), 0);
    check("rst_errcnt", 32'(err_cnt), 0);
    check("rst_ready", 32'(in_ready), 1);

    // Directed encodings from known-good words
    set_fields(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    send_cur("i_neg1");
    check("i_neg1_enc", 32'(enc_cnt), 1);
    pop_check("i_neg1", 32'hFFF00093, 3'd0);
    set_fields(T_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    send_cur("b8");  pop_check("b8", 32'h00208463, 3'd0);
    set_fields(T_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
    send_cur("b7");  pop_check("b7", 32'h0, 3'd2);
    check("b7_errcnt", 32'(err_cnt), 1);
    check("b7_enc", 32'(enc_cnt), 3);
    set_fields(T_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
    send_cur("j_m4");  pop_check("j_m4", 32'hFFDFF0EF, 3'd0);
    set_fields(T_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    send_cur("u_ok");  pop_check("u_ok", 32'h123452B7, 3'd0);
    set_fields(T_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
    send_cur("u_al");  pop_check("u_al", 32'h0, 3'd2);
    set_fields(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send_cur("i_2048");  pop_check("i_2048", 32'h0, 3'd1);
    set_fields(T_I, 7'h13, 5'd16, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send_cur("i_rd16");  pop_check("i_rd16", 32'h0, 3'd3);
    set_fields(3'd7, 7'h13, 5'd16, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send_cur("t7_rd16");  pop_check("t7_rd16", 32'h0, 3'd4);
    check("dir_enc", 32'(enc_cnt), 9);
    check("dir_errcnt", 32'(err_cnt), 5);

    // Backpressure: fill, hold third, then drain in order
    out_ready = 1'b0;
    set_fields(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_ready1", 32'(in_ready), 1);
    in_imm32 = 32'd2;
    @(negedge clk);
    check("bp_ready2", 32'(in_ready), 0);
    in_imm32 = 32'd3;
    @(negedge clk);
    check("bp_held", 32'(in_ready), 0);
    check("bp_head", out_inst, 32'h00100093);
    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      automatic bit acc = in_valid && in_ready;
      if (out_valid) got.push_back(out_inst);
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    check("bp_count", 32'(got.size()), 3);
    while (got.size() < 3) got.push_back(32'hDEADBEEF);
    check("bp_w0", got[0], 32'h00100093);
    check("bp_w1", got[1], 32'h00200093);
    check("bp_w2", got[2], 32'h00300093);
    check("bp_enc", 32'(enc_cnt), 12);

    // Reset while two words are queued
    set_fields(T_R, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    send_cur("rq0");  send_cur("rq1");
    check("rq_full", 32'(in_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rq_valid", 32'(out_valid), 0);
    check("rq_enc", 32'(enc_cnt), 0);
    check("rq_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rq_stay_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Clear concurrent with a push
    set_fields(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    send_cur("clr_pre");
    check("clr_pre_errcnt", 32'(err_cnt), 1);
    set_fields(T_R, 7'h33, 5'd3, 5'd4, 5'd5, 3'd7, 7'h20, 32'd0);
    clr_cnt = 1'b1;
    send_cur("clr_push");
    clr_cnt = 1'b0;
    check("clr_enc", 32'(enc_cnt), 0);
    check("clr_errcnt", 32'(err_cnt), 0);
    pop_check("clr_h0", 32'h0, 3'd4);
    pop_check("clr_h1", 32'h405271B3, 3'd0);

    // Saturation of both counters
    out_ready = 1'b1;
    set_fields(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int k = 0; k < 17; k++) send_cur("sat");
    check("sat_enc", 32'(enc_cnt), 15);
    check("sat_errcnt", 32'(err_cnt), 15);
    out_ready = 1'b0;

    // Randomized traffic against the queue model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    begin
      int m_enc = 0;
      int m_err = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        logic [34:0] e;
        bit push, pop;
        check("rnd_valid", 32'(out_valid), (q.size() > 0) ? 1 : 0);
        check("rnd_ready", 32'(in_ready), (q.size() < DEPTH) ? 1 : 0);
        if (q.size() > 0) begin
          check("rnd_inst", out_inst, q[0][31:0]);
          check("rnd_code", 32'(out_errcode), 32'(q[0][34:32]));
          check("rnd_err", 32'(out_err), (q[0][34:32] != 0) ? 1 : 0);
        end
        check("rnd_enc", 32'(enc_cnt), m_enc);
        check("rnd_errcnt", 32'(err_cnt), m_err);
        in_valid  = ($urandom_range(0, 2) != 0);
        out_ready = ($urandom_range(0, 1) != 0);
        clr_cnt   = ($urandom_range(0, 49) == 0);
        set_fields(($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5)),
                   7'($urandom), rand_reg(), rand_reg(), rand_reg(), 3'($urandom), 7'($urandom),
                   rand_imm());
        e = ref_enc(in_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm32);
        push = in_valid && (q.size() < DEPTH);
        pop  = out_ready && (q.size() > 0);
        @(negedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        if (clr_cnt) begin
          m_enc = 0;
          m_err = 0;
        end else if (push) begin
          if (m_enc < 15) m_enc++;
          if (e[34:32] != 0 && m_err < 15) m_err++;
        end
      end
    end
    in_valid = 1'b0;
    clr_cnt = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
